// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: state encoding and grant constants.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int unsigned TO_CNT_W = 16;

    // One-hot owner view of the arbiter state.
    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        g = GRANT_NONE;
        case (st)
            OWN0:    g = GRANT_M0;
            OWN1:    g = GRANT_M1;
            default: g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stalled-access watchdog: counts run cycles and flags expiry at TIMEOUT_CYCLES.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    logic [TO_CNT_W-1:0] r_cnt;

    assign o_expire = (r_cnt == TO_CNT_W'(TIMEOUT_CYCLES));

    // Expiry restarts the count so the error is a single-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + TO_CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter with a registered grant and combinational data path.
// Optional access timeout enabled by defining WB_ARB2_TIMEOUT_EN.
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW             = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic [AW-3:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    output logic          o_m0_err,

    input  logic [AW-3:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic          o_m1_err,

    output logic [AW-3:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    output logic          o_s_stb,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,
    input  logic          i_s_err,

    output logic [1:0]    o_grant
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_arb2: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_expire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Arbitration: r_last names the previous owner, so a tie goes to the other master.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        unique case (r_state)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_state_nxt = r_last ? OWN0 : OWN1;
                end else if (i_m0_cyc) begin
                    w_state_nxt = OWN0;
                end else if (i_m1_cyc) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!i_m0_cyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!i_m1_cyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Owner's bus routed to the slave; terminations gated by cyc so aborts swallow late acks.
    always_comb begin
        o_s_adr  = '0;
        o_s_dat  = '0;
        o_s_sel  = '0;
        o_s_we   = 1'b0;
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        case (r_state)
            OWN0: begin
                o_s_adr  = i_m0_adr;
                o_s_dat  = i_m0_dat;
                o_s_sel  = i_m0_sel;
                o_s_we   = i_m0_we;
                o_s_cyc  = i_m0_cyc & ~w_expire;
                o_s_stb  = i_m0_cyc & i_m0_stb & ~w_expire;
                o_m0_ack = i_m0_cyc & i_s_ack & ~w_expire;
                o_m0_err = i_m0_cyc & (i_s_err | w_expire);
            end
            OWN1: begin
                o_s_adr  = i_m1_adr;
                o_s_dat  = i_m1_dat;
                o_s_sel  = i_m1_sel;
                o_s_we   = i_m1_we;
                o_s_cyc  = i_m1_cyc & ~w_expire;
                o_s_stb  = i_m1_cyc & i_m1_stb & ~w_expire;
                o_m1_ack = i_m1_cyc & i_s_ack & ~w_expire;
                o_m1_err = i_m1_cyc & (i_s_err | w_expire);
            end
            default: begin
            end
        endcase
    end

    assign o_m0_rdt = i_s_rdt;
    assign o_m1_rdt = i_s_rdt;
    assign o_grant  = grant_of(r_state);

`ifdef WB_ARB2_TIMEOUT_EN
    logic w_to_run;
    logic w_to_clear;

    assign w_to_run   = o_s_stb & ~i_s_ack & ~i_s_err;
    assign w_to_clear = (r_state == IDLE) | i_s_ack | i_s_err;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (w_to_run),
        .i_clear  (w_to_clear),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arb2.sv
// Directed scoreboard bench for wb_arb2 (timeout steps follow WB_ARB2_TIMEOUT_EN).
module tb_wb_arb2;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-3:0] m0_adr, m1_adr, s_adr;
    logic [31:0]   m0_dat, m1_dat, s_dat, m0_rdt, m1_rdt, s_rdt;
    logic [3:0]    m0_sel, m1_sel, s_sel;
    logic          m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic          m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic          s_we, s_cyc, s_stb, s_ack, s_err;
    logic [31:0]   s_rdt_in;
    logic [1:0]    grant;

    int            n_vec = 0;
    int            n_err = 0;
    logic [63:0]   q_exp[$];

    always #5 clk = ~clk;

    wb_arb2 #(.AW(AW), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
        .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
        .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb),
        .i_s_rdt(s_rdt_in), .i_s_ack(s_ack), .i_s_err(s_err),
        .o_grant(grant)
    );

    assign s_rdt = s_rdt_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        chk({tag, "_queued"}, 64'(q_exp.size() != 0), 64'd1);
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_all();
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_rdt_in = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    initial begin
        idle_all();
        // reset values
        smp();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // m0 single read, slave acks after 3 wait cycles
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 10'h055; m0_sel = 4'hF;
        q_exp.push_back(64'h0000_0000_1234_5678);
        smp();
        chk("t1_nocomb_grant", 64'(grant), 64'd0);
        chk("t1_nocomb_s_cyc", 64'(s_cyc), 64'd0);
        step();
        smp();
        chk("t1_grant", 64'(grant), 64'(2'b01));
        chk("t1_s_cyc", 64'(s_cyc), 64'd1);
        chk("t1_s_adr", 64'(s_adr), 64'h055);
        chk("t1_s_we", 64'(s_we), 64'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            smp();
            chk("t1_wait_ack", 64'(m0_ack), 64'd0);
        end
        step();
        s_ack = 1'b1; s_rdt_in = 32'h1234_5678;
        smp();
        chk("t1_m0_ack", 64'(m0_ack), 64'd1);
        chk("t1_m1_ack", 64'(m1_ack), 64'd0);
        if (m0_ack) pop_chk("t1_m0_rdt", 64'(m0_rdt));
        step();
        idle_all();
        smp();
        chk("t1_ack_pulse", 64'(m0_ack), 64'd0);
        chk("t1_rel_s_cyc", 64'(s_cyc), 64'd0);
        step();
        smp();
        chk("t1_idle", 64'(grant), 64'd0);
        chk("t1_q_empty", 64'(q_exp.size()), 64'd0);

        // tie after reset goes to m0; m1 follows after one idle cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 10'h011;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 10'h022;
        q_exp.push_back(64'h0000_0000_CAFE_0000);
        q_exp.push_back(64'h0000_0000_BEEF_0001);
        step();
        smp();
        chk("t2_first_grant", 64'(grant), 64'(2'b01));
        chk("t2_s_adr_m0", 64'(s_adr), 64'h011);
        step();
        s_ack = 1'b1; s_rdt_in = 32'hCAFE_0000;
        smp();
        chk("t2_m0_ack", 64'(m0_ack), 64'd1);
        chk("t2_m1_ack_off", 64'(m1_ack), 64'd0);
        if (m0_ack) pop_chk("t2_m0_rdt", 64'(m0_rdt));
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        smp();
        chk("t2_rel_grant", 64'(grant), 64'(2'b01));
        chk("t2_rel_s_cyc", 64'(s_cyc), 64'd0);
        step();
        smp();
        chk("t2_gap", 64'(grant), 64'd0);
        chk("t2_gap_s_cyc", 64'(s_cyc), 64'd0);
        step();
        smp();
        chk("t2_second_grant", 64'(grant), 64'(2'b10));
        chk("t2_s_adr_m1", 64'(s_adr), 64'h022);
        step();
        s_ack = 1'b1; s_rdt_in = 32'hBEEF_0001;
        smp();
        chk("t2_m1_ack", 64'(m1_ack), 64'd1);
        chk("t2_m0_ack_off", 64'(m0_ack), 64'd0);
        if (m1_ack) pop_chk("t2_m1_rdt", 64'(m1_rdt));
        step();
        idle_all();
        step();
        chk("t2_q_empty", 64'(q_exp.size()), 64'd0);

        // m1 holds the bus for 4 writes while m0 waits
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF;
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            m1_adr = 10'(16 + i);
            m1_dat = 32'hA5A5_0000 + 32'(i);
            s_ack = 1'b1;
            q_exp.push_back({22'd0, 10'(16 + i), 32'hA5A5_0000 + 32'(i)});
            smp();
            chk("t3_grant", 64'(grant), 64'(2'b10));
            chk("t3_m1_ack", 64'(m1_ack), 64'd1);
            chk("t3_m0_ack", 64'(m0_ack), 64'd0);
            chk("t3_s_we", 64'(s_we), 64'd1);
            if (s_stb && s_ack) pop_chk("t3_write", {22'd0, s_adr, s_dat});
        end
        step();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        smp();
        chk("t3_rel_s_cyc", 64'(s_cyc), 64'd0);
        step();
        smp();
        chk("t3_gap", 64'(grant), 64'd0);
        step();
        smp();
        chk("t3_m0_grant", 64'(grant), 64'(2'b01));
        chk("t3_m0_adr", 64'(s_adr), 64'h3FF);
        chk("t3_q_empty", 64'(q_exp.size()), 64'd0);
        step();
        idle_all();
        step();

        // m0 aborts before ack; late slave ack is swallowed
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 10'h077;
        step();
        smp();
        chk("t4_grant", 64'(grant), 64'(2'b01));
        chk("t4_s_cyc", 64'(s_cyc), 64'd1);
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        smp();
        chk("t4_abort_s_cyc", 64'(s_cyc), 64'd0);
        chk("t4_abort_s_stb", 64'(s_stb), 64'd0);
        chk("t4_abort_m0_ack", 64'(m0_ack), 64'd0);
        step();
        s_ack = 1'b1;
        smp();
        chk("t4_late_m0_ack", 64'(m0_ack), 64'd0);
        chk("t4_late_m1_ack", 64'(m1_ack), 64'd0);
        chk("t4_late_s_cyc", 64'(s_cyc), 64'd0);
        step();
        s_ack = 1'b0;
        step();

`ifdef WB_ARB2_TIMEOUT_EN
        // slave never answers: error pulse 8 cycles after stb
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            step();
            smp();
            chk("t5_no_err_yet", 64'(m0_err), 64'd0);
            chk("t5_s_cyc_held", 64'(s_cyc), 64'd1);
        end
        step();
        smp();
        chk("t5_err_pulse", 64'(m0_err), 64'd1);
        chk("t5_err_s_cyc", 64'(s_cyc), 64'd0);
        chk("t5_err_s_stb", 64'(s_stb), 64'd0);
        chk("t5_err_m1", 64'(m1_err), 64'd0);
        step();
        smp();
        chk("t5_err_single", 64'(m0_err), 64'd0);
        chk("t5_s_cyc_back", 64'(s_cyc), 64'd1);
        chk("t5_grant_kept", 64'(grant), 64'(2'b01));
        step();
        idle_all();
        step();
`else
        // without the timeout an access waits indefinitely
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            smp();
            chk("t5_no_err", 64'(m0_err), 64'd0);
            chk("t5_s_cyc_held", 64'(s_cyc), 64'd1);
        end
        step();
        s_ack = 1'b1;
        smp();
        chk("t5_late_ack", 64'(m0_ack), 64'd1);
        step();
        idle_all();
        step();
`endif

        // async reset mid-access, then a tie must go to m0
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        smp();
        chk("t6_s_cyc", 64'(s_cyc), 64'd1);
        #2;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("t6_rst_s_stb", 64'(s_stb), 64'd0);
        chk("t6_rst_grant", 64'(grant), 64'd0);
        chk("t6_rst_m0_ack", 64'(m0_ack), 64'd0);
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        rst_n = 1'b1;
        s_ack = 1'b0;
        smp();
        chk("t6_post_rst_idle", 64'(grant), 64'd0);
        step();
        smp();
        chk("t6_tie_m0", 64'(grant), 64'(2'b01));
        step();
        idle_all();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
